lector_eventos_botones: RTL
===========================

Name: lector_eventos_botones

Overview:
- Consumer end of the debounced button/sensor front-end.
- Inputs are the toggle-per-press level signals from the front-end: energia, medicina, test-activado, fotocelda and ultrasonido. Each one flips once per debounced press.
- The block converts every level change into a one-event code, queues it in a small FIFO and hands it to the pet state machine over a valid/ready handshake.
- Inputs are treated as asynchronous to clk, because they are produced by edge-triggered logic on debounced nets.

Parameters:
- FIFO_DEPTH, default 4: event FIFO entries; must be a power of two, minimum 2.
- ARM_CYCLES, default 3: clk cycles after reset release during which input changes are absorbed without generating events.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- senal_energia  in  1  toggle-level from energia button.
- senal_medicina  in  1  toggle-level from medicina button.
- senal_test_activado  in  1  toggle-level for test mode.
- senal_fot  in  1  toggle-level from fotocelda.
- senal_ultrasonido  in  1  toggle-level from ultrasonido.
- evt_valid  out  1  FIFO head holds an event.
- evt_code  out  3  head event code: 1 energia, 2 medicina, 3 test, 4 fot, 5 ultrasonido; 0 when empty.
- evt_ready  in  1  consumer accepts head this cycle.
- modo_test  out  1  synchronized level of senal_test_activado.
- overflow  out  1  sticky: an event was lost.
- overflow_clr  in  1  synchronous clear of overflow.
- drop_count  out  8  lost-event counter (see Optional Feature).

Behaviour:
- Reset values: all synchronizer stages 0, prev 0, pending 0, FIFO empty, evt_valid 0, evt_code 0, modo_test 0, overflow 0, drop_count 0.
- Synchronizer, per input: two flops s1→s2, then prev <= s2.
  - edge = s2 XOR prev.
  - modo_test = s2 of senal_test_activado.
- Arming:
  - A counter runs ARM_CYCLES cycles after reset deassert.
  - While it runs, prev tracks s2 but edge is masked, so an input already high at reset produces no event.
- Pending register: one bit per source, pending <= (pending & ~granted) | edge.
- Lost event: edge on a source whose pending bit is already 1 and not granted that cycle.
  - Sets overflow.
  - Increments drop_count.
- Arbiter, one grant per cycle when the FIFO can accept.
  - Fixed priority: test > energia > medicina > ultrasonido > fot.
  - Granted code is pushed into the FIFO.
  - Non-granted pending bits wait; they are never dropped.
- FIFO can accept when not full, or when full and a pop occurs the same cycle.
- FIFO handshake:
  - Pop when evt_valid & evt_ready.
  - evt_code/evt_valid are registered outputs of the head.
  - Head is stable while evt_valid=1 and evt_ready=0.
  - Push to an empty FIFO is visible on the next cycle, so there is no combinational input-to-output path.
- Latency with FIFO empty and no other pending: input change first sampled at edge E0; s2 at E1; pending at E2; push at E3; evt_valid=1 after E3.
- Pointers:
  - log2(FIFO_DEPTH)+1 bits with wrap bit.
  - Full = indices equal and wrap bits differ.
  - Empty = pointers equal.
- Simultaneous push and pop on a non-empty FIFO: both happen; occupancy unchanged.
- Overflow register:
  - overflow_clr and a new loss in the same cycle: overflow stays 1.
  - overflow_clr does not affect drop_count.
- Back-pressure with evt_ready=0 indefinitely: FIFO fills, pending bits hold; only repeat edges on an already-pending source are lost.
- Reset mid-operation: immediate return to reset values; queued and pending events are discarded; arming restarts on deassert.

Optional Feature:
- Macro: LECTOR_EVT_DROP_CNT_EN.
- Defined: drop_count is an 8-bit counter that saturates at 255 and is cleared only by reset.
- Undefined: the drop_count port remains and is driven constant 0; overflow behaviour is unchanged.

Test Plan:
- Reset release with senal_energia=1 held high, ARM_CYCLES=3 → no evt_valid for 20 cycles; overflow=0.
- With evt_ready=1, toggle senal_medicina 0→1 → evt_valid=1, evt_code=2 for exactly one cycle, starting after the 4th rising edge counted from the sampling edge.
- Toggle energia, test and fot in the same cycle with evt_ready=0 → after settling, FIFO pops in order 3, 1, 4 when ready is raised; no loss.
- Hold evt_ready=0; toggle energia 6 times spaced 5 cycles apart (FIFO_DEPTH=4) → 4 queued, 1 pending, 1 lost; overflow=1; drop_count=1 with macro defined, 0 without.
- Assert overflow_clr and create a loss in the same cycle → overflow remains 1; next cycle with clr only → overflow=0.
- Assert reset while 3 events are queued → evt_valid drops to 0 asynchronously; after release no stale event appears.

Source files
------------

// File: rtl/lector_eventos_botones.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : lector_eventos_botones
//  Description : Consumer end of the debounced button/sensor front-end.
//                Turns each level change on the five toggle-per-press
//                inputs into a one-event code. The code goes through a
//                per-source pending bit, a fixed-priority arbiter and a
//                small FIFO, and leaves on a valid/ready handshake.
//  Optional    : LECTOR_EVT_DROP_CNT_EN - when defined, drop_count is a
//                saturating 8-bit lost-event counter. When undefined,
//                drop_count is tied to 0.
//  Ports       : clk, reset (async, active-high)
//                senal_energia / senal_medicina / senal_test_activado /
//                senal_fot / senal_ultrasonido : async toggle levels
//                evt_valid, evt_code[2:0], evt_ready : event handshake
//                modo_test : synchronized test level
//                overflow (sticky), overflow_clr : event-loss flag
//                drop_count[7:0] : lost-event count
//  Revision    : 1.0 - initial release
// ============================================================================
module lector_eventos_botones #(
    parameter int FIFO_DEPTH = 4,   // power of two, >= 2
    parameter int ARM_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       senal_energia,
    input  logic       senal_medicina,
    input  logic       senal_test_activado,
    input  logic       senal_fot,
    input  logic       senal_ultrasonido,
    output logic       evt_valid,
    output logic [2:0] evt_code,
    input  logic       evt_ready,
    output logic       modo_test,
    output logic       overflow,
    input  logic       overflow_clr,
    output logic [7:0] drop_count
);

    localparam int c_NSRC = 5;
    localparam int c_AW   = $clog2(FIFO_DEPTH);
    localparam int c_PW   = c_AW + 1;
    localparam int c_CW   = (ARM_CYCLES > 0) ? $clog2(ARM_CYCLES + 1) : 1;
    localparam logic [c_CW-1:0] c_ARM = c_CW'(ARM_CYCLES);

    // Bit position of each source inside the internal source vectors.
    localparam int c_ENERGIA  = 0;
    localparam int c_MEDICINA = 1;
    localparam int c_TEST     = 2;
    localparam int c_FOT      = 3;
    localparam int c_ULTRA    = 4;

    logic [c_NSRC-1:0] w_raw;
    assign w_raw = {senal_ultrasonido, senal_fot, senal_test_activado,
                    senal_medicina, senal_energia};

    // ------------------------------------------------------------------
    // Two-flop synchronizers plus a previous-value stage for edge detection
    // ------------------------------------------------------------------
    logic [c_NSRC-1:0] s1_q, s2_q, prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= w_raw;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign modo_test = s2_q[c_TEST];

    // ------------------------------------------------------------------
    // Arming: for the first ARM_CYCLES edges after reset, prev still follows
    // s2 but edges are discarded. Inputs that are already high when reset
    // is released therefore produce no event.
    // ------------------------------------------------------------------
    logic [c_CW-1:0] arm_cnt_q, arm_cnt_d;
    logic            w_armed;

    assign w_armed = (arm_cnt_q >= c_ARM);

    always_comb begin
        arm_cnt_d = arm_cnt_q;
        if (!w_armed) begin
            arm_cnt_d = arm_cnt_q + c_CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm_cnt_q <= '0;
        end else begin
            arm_cnt_q <= arm_cnt_d;
        end
    end

    logic [c_NSRC-1:0] w_edge;
    assign w_edge = w_armed ? (s2_q ^ prev_q) : '0;

    // ------------------------------------------------------------------
    // FIFO pointers: one extra wrap bit separates full from empty.
    // ------------------------------------------------------------------
    logic [c_PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]      mem_q [FIFO_DEPTH];
    logic            w_empty, w_full, w_pop, w_push, w_can_push;

    assign w_empty    = (wr_ptr_q == rd_ptr_q);
    assign w_full     = (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]) &&
                        (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]);
    assign evt_valid  = !w_empty;
    assign w_pop      = evt_valid & evt_ready;
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign w_can_push = !w_full || w_pop;

    // The head comes only from registers (pointers and storage). A push is
    // therefore visible one cycle later, and evt_ready has no path to the
    // outputs inside the same cycle.
    assign evt_code = w_empty ? 3'd0 : mem_q[rd_ptr_q[c_AW-1:0]];

    // ------------------------------------------------------------------
    // Pending bits and fixed-priority arbiter
    // (test > energia > medicina > ultrasonido > fot)
    // ------------------------------------------------------------------
    logic [c_NSRC-1:0] pending_q, pending_d, w_grant, w_lost;
    logic [2:0]        w_code;

    always_comb begin
        w_grant = '0;
        w_code  = 3'd0;
        if (w_can_push) begin
            if (pending_q[c_TEST]) begin
                w_grant[c_TEST] = 1'b1;
                w_code          = 3'd3;
            end else if (pending_q[c_ENERGIA]) begin
                w_grant[c_ENERGIA] = 1'b1;
                w_code             = 3'd1;
            end else if (pending_q[c_MEDICINA]) begin
                w_grant[c_MEDICINA] = 1'b1;
                w_code              = 3'd2;
            end else if (pending_q[c_ULTRA]) begin
                w_grant[c_ULTRA] = 1'b1;
                w_code           = 3'd5;
            end else if (pending_q[c_FOT]) begin
                w_grant[c_FOT] = 1'b1;
                w_code         = 3'd4;
            end
        end
    end

    assign w_push    = |w_grant;
    // A repeat edge on a source that is still waiting has nowhere to go.
    assign w_lost    = w_edge & pending_q & ~w_grant;
    assign pending_d = (pending_q & ~w_grant) | w_edge;
    assign wr_ptr_d  = wr_ptr_q + c_PW'(w_push);
    assign rd_ptr_d  = rd_ptr_q + c_PW'(w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            pending_q <= pending_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Storage needs no reset: it is read only while the pointers say valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q[c_AW-1:0]] <= w_code;
        end
    end

    // ------------------------------------------------------------------
    // Sticky overflow: a new loss wins over a simultaneous clear.
    // ------------------------------------------------------------------
    logic overflow_q, overflow_d;

    assign overflow_d = (overflow_q & ~overflow_clr) | (|w_lost);
    assign overflow   = overflow_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

`ifdef LECTOR_EVT_DROP_CNT_EN
    // Several sources can lose an edge in the same cycle, so add the whole
    // count and saturate at 255.
    logic [7:0] drop_q, drop_d;
    logic [2:0] w_nlost;
    logic [8:0] w_sum;

    always_comb begin
        w_nlost = 3'd0;
        for (int i = 0; i < c_NSRC; i++) begin
            w_nlost = w_nlost + {2'b00, w_lost[i]};
        end
        w_sum  = {1'b0, drop_q} + {6'd0, w_nlost};
        drop_d = w_sum[8] ? 8'hFF : w_sum[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= 8'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 8'd0;
`endif

endmodule
`default_nettype wire
